// File: rtl/fft_frame_loader.sv
// fft_frame_loader: assembles a stream of complex samples into complete
// N-sample frames and presents each frame as a flat parallel bus for the
// 32-point FFT core. A ping-pong pair of banks lets one frame fill while the
// previous frame is held stable for the consumer.
//
// Optional build macro:
//   FFT_FRAME_LOADER_BITREV_EN - store sample i at slot bitrev(i) instead of
//                                slot i (decimation-in-time input order).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (clears all state and banks)
//   flush        synchronous; abandons the partially filled write bank
//   s_data       complex input sample, real [SW-1:SW/2], imag [SW/2-1:0]
//   s_valid      s_data is valid
//   s_ready      loader accepts a sample this cycle
//   frame_data   assembled frame, slot k at [SW*k+SW-1 : SW*k]
//   frame_valid  frame_data holds a complete frame
//   frame_ready  consumer takes the frame this cycle
//   wr_count     samples accepted into the current write bank
module fft_frame_loader #(
  parameter int unsigned LOG2N = 5,
  parameter int unsigned SW    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [SW-1:0]              s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [(2**LOG2N)*SW-1:0]   frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [LOG2N-1:0]           wr_count
);

  localparam int unsigned N = 2 ** LOG2N;

  // Storage and bookkeeping
  logic [N-1:0][SW-1:0] bank0;
  logic [N-1:0][SW-1:0] bank1;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [LOG2N-1:0]     wr_idx;
  logic [1:0]           full;

  // Next-state values
  logic                 wr_bank_n;
  logic                 rd_bank_n;
  logic [LOG2N-1:0]     wr_idx_n;
  logic [1:0]           full_n;

  logic                 accept;
  logic                 rel;
  logic                 last;
  logic [LOG2N-1:0]     wr_slot;

  // Slot a write index lands in: natural order or bit-reversed order
  function automatic logic [LOG2N-1:0] slot_of(input logic [LOG2N-1:0] i);
    logic [LOG2N-1:0] r;
`ifdef FFT_FRAME_LOADER_BITREV_EN
    for (int b = 0; b < int'(LOG2N); b++) begin
      r[b] = i[int'(LOG2N) - 1 - b];
    end
`else
    r = i;
`endif
    return r;
  endfunction

  // Handshake decode; flush blocks input for the cycle it is asserted
  always_comb begin
    s_ready     = !full[wr_bank] && !flush;
    frame_valid = full[rd_bank];
    accept      = s_valid && s_ready;
    rel         = frame_valid && frame_ready;
    last        = (wr_idx == LOG2N'(N - 1));
    wr_slot     = slot_of(wr_idx);
  end

  // Next-state for indices, bank pointers and full flags. Accept and
  // release always touch different banks, so both updates can apply.
  always_comb begin
    wr_idx_n  = wr_idx;
    wr_bank_n = wr_bank;
    rd_bank_n = rd_bank;
    full_n    = full;
    if (accept) begin
      if (last) begin
        wr_idx_n        = '0;
        wr_bank_n       = !wr_bank;
        full_n[wr_bank] = 1'b1;
      end else begin
        wr_idx_n = wr_idx + LOG2N'(1);
      end
    end else if (flush) begin
      wr_idx_n = '0;
    end
    if (rel) begin
      full_n[rd_bank] = 1'b0;
      rd_bank_n       = !rd_bank;
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      wr_idx  <= wr_idx_n;
      wr_bank <= wr_bank_n;
      rd_bank <= rd_bank_n;
      full    <= full_n;
    end
  end

  // Sample storage; a released bank keeps its data until overwritten
  always_ff @(posedge clk) begin
    if (reset) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (accept) begin
      if (wr_bank) begin
        bank1[wr_slot] <= s_data;
      end else begin
        bank0[wr_slot] <= s_data;
      end
    end
  end

  // Frame bus comes straight from the bank registers
  assign frame_data = rd_bank ? bank1 : bank0;
  assign wr_count   = wr_idx;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: directed and random streams
// compared against a queue-based frame model.
module tb_fft_frame_loader;

  localparam int unsigned LOG2N = 5;
  localparam int unsigned SW    = 64;
  localparam int unsigned N     = 32;
  localparam int unsigned BW    = N * SW;

  logic           clk;
  logic           reset;
  logic           flush;
  logic [SW-1:0]  s_data;
  logic           s_valid;
  logic           s_ready;
  logic [BW-1:0]  frame_data;
  logic           frame_valid;
  logic           frame_ready;
  logic [LOG2N-1:0] wr_count;

  int total;
  int bad;

  // Model: samples of the partial frame in arrival order, complete frames
  // (already laid out as the expected bus) waiting for the consumer.
  logic [SW-1:0] part[$];
  logic [BW-1:0] pend[$];

  fft_frame_loader #(.LOG2N(LOG2N), .SW(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int slot_idx(input int k);
    int r;
    r = 0;
`ifdef FFT_FRAME_LOADER_BITREV_EN
    for (int b = 0; b < int'(LOG2N); b++)
      if (((k >> b) & 1) != 0) r += (1 << (int'(LOG2N) - 1 - b));
`else
    r = k;
`endif
    return r;
  endfunction

  // Lay out an arrival-ordered list of N samples as the expected bus
  function automatic logic [BW-1:0] to_bus(input logic [BW-1:0] arr);
    logic [BW-1:0] bus;
    bus = '0;
    for (int k = 0; k < int'(N); k++) bus[slot_idx(k)*SW +: SW] = arr[k*SW +: SW];
    return bus;
  endfunction

  // First differing slot, used only to keep FAIL lines short
  function automatic int diff_slot(input logic [BW-1:0] a, input logic [BW-1:0] b);
    for (int k = 0; k < int'(N); k++) if (a[k*SW +: SW] !== b[k*SW +: SW]) return k;
    return 0;
  endfunction

  function automatic logic [SW-1:0] pat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v, ~v};
  endfunction

  function automatic bit m_ready(input logic f);
    return (pend.size() < 2) && !f;
  endfunction

  // Advance one clock and update the model from the inputs held at the edge
  task automatic tick();
    bit acc;
    bit rel;
    logic [BW-1:0] arr;
    acc = s_valid && m_ready(flush) && !reset;
    rel = (pend.size() > 0) && frame_ready && !reset;
    @(posedge clk);
    if (reset) begin
      part.delete();
      pend.delete();
    end else begin
      if (rel) void'(pend.pop_front());
      if (acc) begin
        part.push_back(s_data);
        if (part.size() == int'(N)) begin
          for (int k = 0; k < int'(N); k++) arr[k*SW +: SW] = part[k];
          pend.push_back(to_bus(arr));
          part.delete();
        end
      end else if (flush) begin
        part.delete();
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; frame_ready = 1'b0; s_data = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; frame_ready = 1'b0; s_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
    total++; if (wr_count !== '0) begin bad++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    total++; if (frame_data !== '0) begin bad++; $display("FAIL reset_frame_data slot=%0d got=%h exp=0", diff_slot(frame_data, '0), frame_data[diff_slot(frame_data, '0)*SW +: SW]); end
  endtask

  task automatic test_fill();
    logic [SW-1:0] got;
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      s_valid = 1'b1; s_data = pat(i); #1;
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fill_s_ready i=%0d got=%b exp=1", i, s_ready); end
      total++; if (wr_count !== LOG2N'(i)) begin bad++; $display("FAIL fill_wr_count got=%0d exp=%0d", wr_count, i); end
      tick();
    end
    s_valid = 1'b0; #1;
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL fill_latency got=%b exp=1", frame_valid); end
`ifdef FFT_FRAME_LOADER_BITREV_EN
    got = frame_data[20*SW +: SW];
`else
    got = frame_data[5*SW +: SW];
`endif
    total++; if (got !== {32'd5, ~32'd5}) begin bad++; $display("FAIL fill_slot5 got=%h exp=%h", got, {32'd5, ~32'd5}); end
    total++; if (frame_data !== pend[0]) begin bad++; $display("FAIL fill_frame slot=%0d got=%h exp=%h", diff_slot(frame_data, pend[0]), frame_data[diff_slot(frame_data, pend[0])*SW +: SW], pend[0][diff_slot(frame_data, pend[0])*SW +: SW]); end
    for (int i = 0; i < int'(N); i++) begin
      s_valid = 1'b1; s_data = 64'($urandom) << 32 | 64'($urandom); #1;
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fill2_s_ready i=%0d got=%b exp=1", i, s_ready); end
      tick();
    end
    s_valid = 1'b0; #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_both_full got=%b exp=0", s_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [BW-1:0] arr;
    logic [BW-1:0] exp0;
    do_reset();
    n = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      s_valid = 1'b1; s_data = pat(n); #1;
      total++; if (s_ready !== m_ready(1'b0)) begin bad++; $display("FAIL b2b_s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, m_ready(1'b0)); end
      if (cyc >= 64) begin
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall cyc=%0d got=%b exp=0", cyc, s_ready); end
      end
      if (s_ready === 1'b1) n++;
      tick();
    end
    for (int k = 0; k < int'(N); k++) arr[k*SW +: SW] = pat(k);
    exp0 = to_bus(arr);
    frame_ready = 1'b1; #1;
    total++; if (frame_data !== exp0) begin bad++; $display("FAIL b2b_frame0 slot=%0d got=%h exp=%h", diff_slot(frame_data, exp0), frame_data[diff_slot(frame_data, exp0)*SW +: SW], exp0[diff_slot(frame_data, exp0)*SW +: SW]); end
    tick();
    frame_ready = 1'b0; #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_resume got=%b exp=1", s_ready); end
    total++; if (frame_data[SW-1:0] !== pat(32)) begin bad++; $display("FAIL b2b_frame1 got=%h exp=%h", frame_data[SW-1:0], pat(32)); end
    for (int cyc = 0; cyc < 100 && n < 96; cyc++) begin
      s_valid = 1'b1; s_data = pat(n); #1;
      if (s_ready === 1'b1) n++;
      tick();
    end
    s_valid = 1'b0;
    total++; if (n !== 96) begin bad++; $display("FAIL b2b_timeout got=%0d exp=96", n); end
    for (int r = 1; r <= 2; r++) begin
      frame_ready = 1'b1; #1;
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid r=%0d got=%b exp=1", r, frame_valid); end
      total++; if (frame_data[SW-1:0] !== pat(32*r)) begin bad++; $display("FAIL b2b_order r=%0d got=%h exp=%h", r, frame_data[SW-1:0], pat(32*r)); end
      tick();
    end
    frame_ready = 1'b0; #1;
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", frame_valid); end
  endtask

  task automatic test_stream();
    int rels;
    do_reset();
    frame_ready = 1'b1;
    rels = 0;
    for (int cyc = 0; cyc < 132; cyc++) begin
      s_valid = (cyc < 128);
      s_data = 64'($urandom) << 32 | 64'($urandom);
      #1;
      if (cyc < 128) begin
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stream_stall cyc=%0d got=%b exp=1", cyc, s_ready); end
      end
      total++; if (frame_valid !== (pend.size() > 0)) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, frame_valid, pend.size() > 0); end
      if (frame_valid === 1'b1 && pend.size() > 0) begin
        total++; if (frame_data !== pend[0]) begin bad++; $display("FAIL stream_frame slot=%0d got=%h exp=%h", diff_slot(frame_data, pend[0]), frame_data[diff_slot(frame_data, pend[0])*SW +: SW], pend[0][diff_slot(frame_data, pend[0])*SW +: SW]); end
        rels++;
      end
      tick();
    end
    frame_ready = 1'b0;
    total++; if (rels !== 4) begin bad++; $display("FAIL stream_releases got=%0d exp=4", rels); end
  endtask

  task automatic test_flush();
    logic [BW-1:0] arr;
    logic [BW-1:0] exp;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 64'($urandom); tick();
    end
    flush = 1'b1; s_valid = 1'b1; s_data = pat(999); #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL flush_s_ready got=%b exp=0", s_ready); end
    tick();
    flush = 1'b0; s_valid = 1'b0; #1;
    total++; if (wr_count !== '0) begin bad++; $display("FAIL flush_wr_count got=%0d exp=0", wr_count); end
    for (int i = 0; i < int'(N); i++) begin
      s_valid = 1'b1; s_data = pat(100 + i); tick();
    end
    s_valid = 1'b0; #1;
    for (int k = 0; k < int'(N); k++) arr[k*SW +: SW] = pat(100 + k);
    exp = to_bus(arr);
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b exp=1", frame_valid); end
    total++; if (frame_data !== exp) begin bad++; $display("FAIL flush_frame slot=%0d got=%h exp=%h", diff_slot(frame_data, exp), frame_data[diff_slot(frame_data, exp)*SW +: SW], exp[diff_slot(frame_data, exp)*SW +: SW]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < int'(N) + 17; i++) begin
      s_valid = 1'b1; s_data = 64'($urandom) << 32 | 64'($urandom); tick();
    end
    s_valid = 1'b0; #1;
    total++; if (wr_count !== LOG2N'(17)) begin bad++; $display("FAIL mid_wr_count got=%0d exp=17", wr_count); end
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", frame_valid); end
    reset = 1'b1; s_valid = 1'b1; frame_ready = 1'b1; tick();
    reset = 1'b0; s_valid = 1'b0; frame_ready = 1'b0; #1;
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL mid_frame_valid got=%b exp=0", frame_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_s_ready got=%b exp=1", s_ready); end
    total++; if (wr_count !== '0) begin bad++; $display("FAIL mid_wr_count0 got=%0d exp=0", wr_count); end
    total++; if (frame_data !== '0) begin bad++; $display("FAIL mid_frame_data slot=%0d got=%h exp=0", diff_slot(frame_data, '0), frame_data[diff_slot(frame_data, '0)*SW +: SW]); end
  endtask

  task automatic test_accept_release();
    do_reset();
    for (int i = 0; i < 2 * int'(N) - 1; i++) begin
      s_valid = 1'b1; s_data = pat(i); tick();
    end
    s_valid = 1'b0; #1;
    total++; if (wr_count !== LOG2N'(N - 1)) begin bad++; $display("FAIL ar_wr_count got=%0d exp=31", wr_count); end
    s_valid = 1'b1; s_data = pat(63); frame_ready = 1'b1; #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ar_ready_pre got=%b exp=1", s_ready); end
    tick();
    s_valid = 1'b0; frame_ready = 1'b0; #1;
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL ar_valid got=%b exp=1", frame_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ar_s_ready got=%b exp=1", s_ready); end
    total++; if (frame_data[SW-1:0] !== pat(32)) begin bad++; $display("FAIL ar_bank1 got=%h exp=%h", frame_data[SW-1:0], pat(32)); end
    total++; if (frame_data !== pend[0]) begin bad++; $display("FAIL ar_frame slot=%0d got=%h exp=%h", diff_slot(frame_data, pend[0]), frame_data[diff_slot(frame_data, pend[0])*SW +: SW], pend[0][diff_slot(frame_data, pend[0])*SW +: SW]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_stream();
    test_flush();
    test_reset_mid();
    test_accept_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
